// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants and decode helpers for the VGA
// timing generator and the downstream pattern stages.
package vga_timing_pkg;

    localparam int unsigned CNT_W       = 10;
    localparam int unsigned FRAME_CNT_W = 10;

    localparam int unsigned H_DISPLAY = 640;
    localparam int unsigned H_FRONT   = 16;
    localparam int unsigned H_SYNC    = 96;
    localparam int unsigned H_BACK    = 48;
    localparam int unsigned H_TOTAL   = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned H_SYNC_START = H_DISPLAY + H_FRONT;
    localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC - 1;

    localparam int unsigned V_DISPLAY = 480;
    localparam int unsigned V_FRONT   = 10;
    localparam int unsigned V_SYNC    = 2;
    localparam int unsigned V_BACK    = 33;
    localparam int unsigned V_TOTAL   = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned V_SYNC_START = V_DISPLAY + V_FRONT;
    localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

    // 0 = active-low sync, as used by the standard 640x480 mode.
    localparam logic SYNC_POL = 1'b0;

    function automatic logic in_window(input logic [CNT_W-1:0] val,
                                       input logic [CNT_W-1:0] lo,
                                       input logic [CNT_W-1:0] hi);
        return (val >= lo) && (val <= hi);
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: wrap-at-limit counter with carry-out and a registered
// sync-window decode taken from the counter's next value.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned LIMIT      = H_TOTAL,
    parameter int unsigned WIN_LO     = H_SYNC_START,
    parameter int unsigned WIN_HI     = H_SYNC_END,
    parameter logic        ACTIVE_LVL = SYNC_POL
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_count,
    output logic [CNT_W-1:0] o_next,
    output logic             o_carry,
    output logic             o_win
);

    localparam logic [CNT_W-1:0] L_LAST = CNT_W'(LIMIT - 1);
    localparam logic [CNT_W-1:0] L_LO   = CNT_W'(WIN_LO);
    localparam logic [CNT_W-1:0] L_HI   = CNT_W'(WIN_HI);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_next;
    logic             w_carry;
    logic             r_win;

    always_comb begin
        w_carry = i_en && (r_count == L_LAST);
        w_next  = r_count;
        if (w_carry) begin
            w_next = '0;
        end else if (i_en) begin
            w_next = r_count + 1'b1;
        end
    end

    // Reset parks the counter on its last value so the first enabled cycle lands on 0.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_count <= L_LAST;
            r_win   <= ~ACTIVE_LVL;
        end else begin
            r_count <= w_next;
            r_win   <= in_window(w_next, L_LO, L_HI) ? ACTIVE_LVL : ~ACTIVE_LVL;
        end
    end

    assign o_count = r_count;
    assign o_next  = w_next;
    assign o_carry = w_carry;
    assign o_win   = r_win;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: horizontal/vertical counters, registered
// sync/blanking decode, line/frame pulses and an animation frame counter.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned P_H_DISPLAY = H_DISPLAY,
    parameter int unsigned P_H_FRONT   = H_FRONT,
    parameter int unsigned P_H_SYNC    = H_SYNC,
    parameter int unsigned P_H_BACK    = H_BACK,
    parameter int unsigned P_V_DISPLAY = V_DISPLAY,
    parameter int unsigned P_V_FRONT   = V_FRONT,
    parameter int unsigned P_V_SYNC    = V_SYNC,
    parameter int unsigned P_V_BACK    = V_BACK,
    parameter logic        P_SYNC_POL  = SYNC_POL
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   pix_en,
    input  logic [1:0]             frame_step,
    output logic [CNT_W-1:0]       hpos,
    output logic [CNT_W-1:0]       vpos,
    output logic                   hsync,
    output logic                   vsync,
    output logic                   display_on,
    output logic                   line_start,
    output logic                   frame_start,
    output logic [FRAME_CNT_W-1:0] frame_count
);

    localparam int unsigned L_H_TOTAL = P_H_DISPLAY + P_H_FRONT + P_H_SYNC + P_H_BACK;
    localparam int unsigned L_V_TOTAL = P_V_DISPLAY + P_V_FRONT + P_V_SYNC + P_V_BACK;
    localparam logic [CNT_W-1:0] L_HD = CNT_W'(P_H_DISPLAY);
    localparam logic [CNT_W-1:0] L_VD = CNT_W'(P_V_DISPLAY);

    logic [CNT_W-1:0]       w_h_next;
    logic [CNT_W-1:0]       w_v_next;
    logic                   w_h_carry;
    logic                   w_v_carry;
    logic                   r_display_on;
    logic                   r_line_start;
    logic                   r_frame_start;
    logic [FRAME_CNT_W-1:0] r_frame_count;

    vga_axis_counter #(
        .LIMIT      (L_H_TOTAL),
        .WIN_LO     (P_H_DISPLAY + P_H_FRONT),
        .WIN_HI     (P_H_DISPLAY + P_H_FRONT + P_H_SYNC - 1),
        .ACTIVE_LVL (P_SYNC_POL)
    ) u_h_axis (
        .i_clk   (clk),
        .i_reset (reset),
        .i_en    (pix_en),
        .o_count (hpos),
        .o_next  (w_h_next),
        .o_carry (w_h_carry),
        .o_win   (hsync)
    );

    vga_axis_counter #(
        .LIMIT      (L_V_TOTAL),
        .WIN_LO     (P_V_DISPLAY + P_V_FRONT),
        .WIN_HI     (P_V_DISPLAY + P_V_FRONT + P_V_SYNC - 1),
        .ACTIVE_LVL (P_SYNC_POL)
    ) u_v_axis (
        .i_clk   (clk),
        .i_reset (reset),
        .i_en    (w_h_carry),
        .o_count (vpos),
        .o_next  (w_v_next),
        .o_carry (w_v_carry),
        .o_win   (vsync)
    );

    // Horizontal carry already implies pix_en, so pulses are naturally 0 on idle cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_display_on  <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_display_on  <= (w_h_next < L_HD) && (w_v_next < L_VD);
            r_line_start  <= w_h_carry;
            r_frame_start <= w_h_carry && w_v_carry;
            if (w_h_carry && (w_v_next == L_VD)) begin
                r_frame_count <= r_frame_count + FRAME_CNT_W'(frame_step);
            end
        end
    end

    assign display_on  = r_display_on;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;
    assign frame_count = r_frame_count;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: the standard 640x480 instance plus a shrunken-raster
// instance (so vsync and frame_count wrap are reached in a short run).
module tb_vga_timing_gen;

    typedef struct packed {
        logic [9:0] h;
        logic [9:0] v;
        logic       hs;
        logic       vs;
        logic       de;
        logic       ls;
        logic       fs;
        logic [9:0] fc;
    } out_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       pix_en;
    logic [1:0] frame_step;

    always #5 clk = ~clk;

    logic [9:0] a_hpos, a_vpos, a_fc, b_hpos, b_vpos, b_fc;
    logic       a_hs, a_vs, a_de, a_ls, a_fs, b_hs, b_vs, b_de, b_ls, b_fs;

    vga_timing_gen u_dut_std (
        .clk         (clk),
        .reset       (reset),
        .pix_en      (pix_en),
        .frame_step  (frame_step),
        .hpos        (a_hpos),
        .vpos        (a_vpos),
        .hsync       (a_hs),
        .vsync       (a_vs),
        .display_on  (a_de),
        .line_start  (a_ls),
        .frame_start (a_fs),
        .frame_count (a_fc)
    );

    vga_timing_gen #(
        .P_H_DISPLAY (4),
        .P_H_FRONT   (1),
        .P_H_SYNC    (2),
        .P_H_BACK    (1),
        .P_V_DISPLAY (3),
        .P_V_FRONT   (1),
        .P_V_SYNC    (1),
        .P_V_BACK    (1),
        .P_SYNC_POL  (1'b0)
    ) u_dut_small (
        .clk         (clk),
        .reset       (reset),
        .pix_en      (pix_en),
        .frame_step  (frame_step),
        .hpos        (b_hpos),
        .vpos        (b_vpos),
        .hsync       (b_hs),
        .vsync       (b_vs),
        .display_on  (b_de),
        .line_start  (b_ls),
        .frame_start (b_fs),
        .frame_count (b_fc)
    );

    // Raster geometry per instance: [0] standard, [1] shrunken.
    int HD[2] = '{640, 4};
    int HF[2] = '{16, 1};
    int HS[2] = '{96, 2};
    int HB[2] = '{48, 1};
    int VD[2] = '{480, 3};
    int VF[2] = '{10, 1};
    int VS[2] = '{2, 1};
    int VB[2] = '{33, 1};

    int   m_h[2];
    int   m_v[2];
    int   m_fc[2];
    out_t m_out[2];
    out_t q0[$];
    out_t q1[$];

    int n_vec  = 0;
    int n_err  = 0;
    bit done   = 1'b0;

    // Reference: position as a linear pixel index within the frame; outputs
    // are the raster rules evaluated at the new position, active-low syncs.
    task automatic model_step(input int k, input bit rst, input bit en, input int step);
        int ht, vt, p, hlo, vlo;
        ht = HD[k] + HF[k] + HS[k] + HB[k];
        vt = VD[k] + VF[k] + VS[k] + VB[k];
        if (rst) begin
            m_h[k]  = ht - 1;
            m_v[k]  = vt - 1;
            m_fc[k] = 0;
            m_out[k].hs = 1'b1;
            m_out[k].vs = 1'b1;
            m_out[k].de = 1'b0;
            m_out[k].ls = 1'b0;
            m_out[k].fs = 1'b0;
        end else if (en) begin
            p = (m_v[k] * ht + m_h[k] + 1) % (ht * vt);
            m_h[k] = p % ht;
            m_v[k] = p / ht;
            if (m_h[k] == 0 && m_v[k] == VD[k]) m_fc[k] = (m_fc[k] + step) % 1024;
            hlo = HD[k] + HF[k];
            vlo = VD[k] + VF[k];
            m_out[k].hs = !(m_h[k] >= hlo && m_h[k] < hlo + HS[k]);
            m_out[k].vs = !(m_v[k] >= vlo && m_v[k] < vlo + VS[k]);
            m_out[k].de = (m_h[k] < HD[k]) && (m_v[k] < VD[k]);
            m_out[k].ls = (m_h[k] == 0);
            m_out[k].fs = (p == 0);
        end else begin
            m_out[k].ls = 1'b0;
            m_out[k].fs = 1'b0;
        end
        m_out[k].h  = 10'(m_h[k]);
        m_out[k].v  = 10'(m_v[k]);
        m_out[k].fc = 10'(m_fc[k]);
    endtask

    task automatic apply(input bit rst, input bit en, input int step);
        reset      = rst;
        pix_en     = en;
        frame_step = 2'(step);
        model_step(0, rst, en, step);
        model_step(1, rst, en, step);
        q0.push_back(m_out[0]);
        q1.push_back(m_out[1]);
        @(negedge clk);
    endtask

    task automatic check(input int k, input out_t act);
        out_t exp;
        if (k == 0 && q0.size() > 0) begin
            exp = q0.pop_front();
        end else if (k == 1 && q1.size() > 0) begin
            exp = q1.pop_front();
        end else begin
            n_err++;
            $display("FAIL scoreboard_empty[%0d] at %0t: got an output, expected queue entry none", k, $time);
            return;
        end
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL outputs[%0d] at %0t: got h=%0d v=%0d hs=%b vs=%b de=%b ls=%b fs=%b fc=%0d, expected h=%0d v=%0d hs=%b vs=%b de=%b ls=%b fs=%b fc=%0d",
                     k, $time, act.h, act.v, act.hs, act.vs, act.de, act.ls, act.fs, act.fc,
                     exp.h, exp.v, exp.hs, exp.vs, exp.de, exp.ls, exp.fs, exp.fc);
        end
    endtask

    // Monitor: every posedge the DUTs present a new output vector.
    always @(posedge clk) begin
        #1;
        if (!done) begin
            check(0, out_t'({a_hpos, a_vpos, a_hs, a_vs, a_de, a_ls, a_fs, a_fc}));
            check(1, out_t'({b_hpos, b_vpos, b_hs, b_vs, b_de, b_ls, b_fs, b_fc}));
        end
    end

    initial begin
        for (int i = 0; i < 3; i++) apply(1'b1, 1'b0, 0);
        apply(1'b1, 1'b1, 3);
        // Full-rate run: first pixel, display edge 639/640, hsync window, line wrap.
        for (int i = 0; i < 1800; i++) apply(1'b0, 1'b1, int'($urandom_range(0, 3)));
        // Random enable with occasional reset.
        for (int i = 0; i < 30000; i++) begin
            apply(($urandom % 4000) == 0, ($urandom % 10) < 7, int'($urandom_range(0, 3)));
        end
        // Alternating enable.
        for (int i = 0; i < 2000; i++) apply(1'b0, (i % 2) == 0, int'($urandom_range(0, 3)));
        // Fixed step 3 from reset: small raster passes 342 frames and wraps frame_count.
        apply(1'b1, 1'b0, 0);
        for (int i = 0; i < 17000; i++) apply(1'b0, 1'b1, 3);
        // Frozen animation.
        for (int i = 0; i < 600; i++) apply(1'b0, 1'b1, 0);
        done = 1'b1;
        @(negedge clk);
        if (q0.size() != 0 || q1.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d/%0d entries left, expected 0/0", q0.size(), q1.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
